// File: rtl/comma_word_aligner.sv
// comma_word_aligner
// Finds the 8B/10B comma in an unaligned 10-bit deserializer stream at any
// of the ten bit offsets, runs lock / loss-of-sync, and forwards
// symbol-aligned words {a,b,c,d,e,i,f,g,h,j} to the decoder.
module comma_word_aligner #(
  parameter int ALIGN_COUNT = 3,
  parameter int LOSS_COUNT  = 4,
  parameter int GOOD_RUN    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  input  logic       code_err,
  output logic [9:0] data_out,
  output logic       out_valid,
  output logic       comma_out,
  output logic       sync,
  output logic [3:0] offset
);

  // state    | meaning
  // UNLOCKED | hunting for a comma at any offset
  // CHECK    | counting repeat commas at the candidate offset
  // LOCKED   | aligned; words forwarded, decode errors tracked
  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  state_t     state;
  logic [9:0] prev;
  logic [2:0] cnt;
  logic [2:0] err_cnt;
  logic [2:0] good_cnt;

  logic [9:0] win [10];
  logic [9:0] hit;
  logic       found;
  logic [3:0] hit_k;
  logic       lock_now;
  logic [3:0] sel;
  logic       err_ev;

  // Window k starts k bits into the previous word; prev supplies its head.
  for (genvar k = 0; k < 10; k++) begin : g_win
    assign win[k] = 10'({prev, rx_data} >> (10 - k));
    assign hit[k] = (win[k][9:3] == 7'b0011111) || (win[k][9:3] == 7'b1100000);
  end

  // Priority encode: lowest matching offset wins.
  always_comb begin
    found = 1'b0;
    hit_k = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) begin
        found = 1'b1;
        hit_k = 4'(k);
      end
    end
  end

  // Lock decision, output window select and locked-state error event.
  always_comb begin
    lock_now = 1'b0;
    if (rx_valid && found) begin
      if (state == UNLOCKED && ALIGN_COUNT == 1)
        lock_now = 1'b1;
      if (state == CHECK && hit_k == offset && cnt == 3'(ALIGN_COUNT - 1))
        lock_now = 1'b1;
    end
    sel    = lock_now ? hit_k : offset;
    err_ev = code_err || (found && hit_k != offset);
  end

  // Alignment FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNLOCKED;
      prev      <= '0;
      cnt       <= '0;
      err_cnt   <= '0;
      good_cnt  <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      comma_out <= 1'b0;
      sync      <= 1'b0;
      offset    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (rx_valid) begin
        prev <= rx_data;
        if (state == LOCKED || lock_now) begin
          out_valid <= 1'b1;
          data_out  <= win[sel];
          comma_out <= hit[sel];
        end
        case (state)
          UNLOCKED: begin
            if (found) begin
              offset <= hit_k;
              if (lock_now) begin
                state <= LOCKED;
                sync  <= 1'b1;
              end else begin
                state <= CHECK;
                cnt   <= 3'd1;
              end
            end
          end
          CHECK: begin
            if (found) begin
              if (hit_k == offset) begin
                if (lock_now) begin
                  state <= LOCKED;
                  sync  <= 1'b1;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 3'd1;
                end
              end else begin
                offset <= hit_k;
                cnt    <= 3'd1;
              end
            end
          end
          LOCKED: begin
            if (err_ev) begin
              good_cnt <= '0;
              if (err_cnt == 3'(LOSS_COUNT - 1)) begin
                state   <= UNLOCKED;
                sync    <= 1'b0;
                err_cnt <= '0;
                cnt     <= '0;
              end else begin
                err_cnt <= err_cnt + 3'd1;
              end
            end else if (good_cnt == 3'(GOOD_RUN - 1)) begin
              good_cnt <= '0;
              if (err_cnt != 3'd0)
                err_cnt <= err_cnt - 3'd1;
            end else begin
              good_cnt <= good_cnt + 3'd1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comma_word_aligner.sv
// Testbench for comma_word_aligner: hand-computed vector table, directed
// corner sequences and a randomized bit stream checked against a model.
module tb_comma_word_aligner;

  localparam int ALIGN_COUNT = 3;
  localparam int LOSS_COUNT  = 4;
  localparam int GOOD_RUN    = 4;

  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;
  localparam logic [9:0] D215  = 10'b1010101010;
  // K28.5-/D21.5 stream shifted by three bits, cut into deserializer words
  localparam logic [9:0] W0 = 10'b0000011111;
  localparam logic [9:0] W1 = 10'b0101010101;
  localparam logic [9:0] W2 = 10'b0100011111;
  localparam logic [9:0] XW = 10'b0000000111;
  localparam logic [9:0] YW = 10'b1111111111;

  localparam int PH_HUNT    = 0;
  localparam int PH_CONFIRM = 1;
  localparam int PH_LOCK    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       code_err;
  logic [9:0] data_out;
  logic       out_valid;
  logic       comma_out;
  logic       sync;
  logic [3:0] offset;

  always #5 clk = ~clk;

  comma_word_aligner #(
    .ALIGN_COUNT(ALIGN_COUNT),
    .LOSS_COUNT (LOSS_COUNT),
    .GOOD_RUN   (GOOD_RUN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .code_err (code_err),
    .data_out (data_out),
    .out_valid(out_valid),
    .comma_out(comma_out),
    .sync     (sync),
    .offset   (offset)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [9:0] m_prev, m_data;
  logic       m_ov, m_comma, m_sync;
  int         m_off, m_phase, m_cnt, m_err, m_good;

  bit         bq[$];
  logic [9:0] ksym;

  typedef struct packed {
    logic [9:0] d;
    logic       v;
    logic       e;
    logic       ov;
    logic [9:0] dout;
    logic       cm;
    logic       sy;
    logic [3:0] off;
  } vec_t;
  vec_t tbl [11];

  function automatic logic is_comma(input logic [9:0] w);
    return (w[9:3] == 7'b0011111) || (w[9:3] == 7'b1100000);
  endfunction

  function automatic logic [9:0] window(input logic [9:0] p, input logic [9:0] r, input int k);
    logic [19:0] h;
    logic [9:0]  w;
    h = {p, r};
    for (int j = 0; j < 10; j++) w[9-j] = h[19-k-j];
    return w;
  endfunction

  function automatic int first_comma(input logic [9:0] p, input logic [9:0] r);
    for (int k = 0; k < 10; k++)
      if (is_comma(window(p, r, k))) return k;
    return -1;
  endfunction

  task automatic model_step(input logic [9:0] d, input logic v, input logic e, input logic r);
    int k, old_off, sel;
    bit lock_now, emit, err_ev;
    if (r) begin
      m_prev = '0; m_data = '0; m_ov = 1'b0; m_comma = 1'b0; m_sync = 1'b0;
      m_off = 0; m_phase = PH_HUNT; m_cnt = 0; m_err = 0; m_good = 0;
      return;
    end
    m_ov = 1'b0;
    if (!v) return;
    k        = first_comma(m_prev, d);
    old_off  = m_off;
    emit     = (m_phase == PH_LOCK);
    lock_now = 1'b0;
    if (m_phase == PH_HUNT) begin
      if (k >= 0) begin
        m_off = k;
        m_cnt = 1;
        if (m_cnt >= ALIGN_COUNT) begin lock_now = 1'b1; m_phase = PH_LOCK; end
        else m_phase = PH_CONFIRM;
      end
    end else if (m_phase == PH_CONFIRM) begin
      if (k == m_off) begin
        m_cnt++;
        if (m_cnt >= ALIGN_COUNT) begin lock_now = 1'b1; m_phase = PH_LOCK; end
      end else if (k >= 0) begin
        m_off = k;
        m_cnt = 1;
      end
    end else begin
      err_ev = e || (k >= 0 && k != m_off);
      if (err_ev) begin
        m_good = 0;
        m_err++;
        if (m_err >= LOSS_COUNT) begin m_phase = PH_HUNT; m_err = 0; m_cnt = 0; end
      end else begin
        m_good++;
        if (m_good >= GOOD_RUN) begin m_good = 0; m_err = (m_err > 0) ? m_err - 1 : 0; end
      end
    end
    if (emit || lock_now) begin
      sel     = lock_now ? k : old_off;
      m_data  = window(m_prev, d, sel);
      m_comma = is_comma(m_data);
      m_ov    = 1'b1;
    end
    m_sync = (m_phase == PH_LOCK);
    m_prev = d;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("data_out",  32'(data_out),  32'(m_data));
    chk("comma_out", 32'(comma_out), 32'(m_comma));
    chk("sync",      32'(sync),      32'(m_sync));
    chk("offset",    32'(offset),    32'(m_off));
  endtask

  task automatic cycle(input logic [9:0] d, input logic v, input logic e, input logic r);
    reset    = r;
    rx_data  = d;
    rx_valid = v;
    code_err = e;
    model_step(d, v, e, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic push_bits(input logic [9:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(val[i]);
  endtask

  task automatic pop_word(output logic [9:0] w);
    for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
  endtask

  task automatic send(input logic e);
    logic [9:0] w;
    while (bq.size() < 10) begin
      push_bits(ksym, 10);
      push_bits(D215, 10);
    end
    pop_word(w);
    cycle(w, 1'b1, e, 1'b0);
  endtask

  task automatic gap();
    cycle(10'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restart(input logic [9:0] k, input int pad);
    cycle(10'd0, 1'b1, 1'b0, 1'b1);
    bq.delete();
    ksym = k;
    if (pad > 0) push_bits(10'd0, pad);
  endtask

  initial begin
    int pulses;
    logic [9:0] w;
    logic v, e, r;

    tbl[0]  = '{W0,    1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{W1,    1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 4'd3};
    tbl[2]  = '{W2,    1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 4'd3};
    tbl[3]  = '{W1,    1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 4'd3};
    tbl[4]  = '{W2,    1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 4'd3};
    tbl[5]  = '{W1,    1'b1, 1'b0, 1'b1, K_NEG, 1'b1, 1'b1, 4'd3};
    tbl[6]  = '{W2,    1'b1, 1'b0, 1'b1, D215,  1'b0, 1'b1, 4'd3};
    tbl[7]  = '{W1,    1'b1, 1'b0, 1'b1, K_NEG, 1'b1, 1'b1, 4'd3};
    tbl[8]  = '{YW,    1'b0, 1'b1, 1'b0, K_NEG, 1'b1, 1'b1, 4'd3};
    tbl[9]  = '{W2,    1'b1, 1'b0, 1'b1, D215,  1'b0, 1'b1, 4'd3};
    tbl[10] = '{W1,    1'b1, 1'b0, 1'b1, K_NEG, 1'b1, 1'b1, 4'd3};

    // reset state
    cycle(10'h3FF, 1'b1, 1'b0, 1'b1);
    cycle(10'h3FF, 1'b1, 1'b1, 1'b1);
    chk("rst_sync", 32'(sync), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_offset", 32'(offset), 0);

    // offset-3 lock, K28.5-/D21.5 stream
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].d, tbl[i].v, tbl[i].e, 1'b0);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_data_out", i),  32'(data_out),  32'(tbl[i].dout));
      chk($sformatf("tbl%0d_comma_out", i), 32'(comma_out), 32'(tbl[i].cm));
      chk($sformatf("tbl%0d_sync", i),      32'(sync),      32'(tbl[i].sy));
      chk($sformatf("tbl%0d_offset", i),    32'(offset),    32'(tbl[i].off));
    end

    // offset-0 lock with K28.5+, rx_valid gaps between words
    restart(K_POS, 0);
    for (int i = 0; i < 5; i++) begin send(1'b0); gap(); end
    send(1'b0);
    chk("off0_sync", 32'(sync), 1);
    chk("off0_offset", 32'(offset), 0);
    chk("off0_data", 32'(data_out), 32'(K_POS));
    chk("off0_valid", 32'(out_valid), 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      gap();
      pulses += int'(out_valid);
      send(1'b0);
      pulses += int'(out_valid);
    end
    chk("gap_pulses", 32'(pulses), 8);

    // two commas at 3, then the stream slips to offset 7
    restart(K_NEG, 3);
    push_bits(K_NEG, 10); push_bits(D215, 10); push_bits(K_NEG, 10); push_bits(D215, 10);
    push_bits(10'b1010, 4);
    push_bits(K_NEG, 10); push_bits(D215, 10); push_bits(K_NEG, 10); push_bits(D215, 10);
    for (int i = 0; i < 5; i++) send(1'b0);
    chk("slip_before_off", 32'(offset), 3);
    send(1'b0);
    chk("slip_off7", 32'(offset), 7);
    chk("slip_sync0_a", 32'(sync), 0);
    send(1'b0); send(1'b0);
    chk("slip_sync0_b", 32'(sync), 0);
    send(1'b0); send(1'b0);
    chk("slip_lock", 32'(sync), 1);
    chk("slip_lock_off", 32'(offset), 7);
    chk("slip_lock_data", 32'(data_out), 32'(K_NEG));

    // errors spaced by fewer than GOOD_RUN good words drop lock
    restart(K_NEG, 3);
    for (int i = 0; i < 6; i++) send(1'b0);
    chk("loss_locked", 32'(sync), 1);
    for (int g = 0; g < 3; g++) begin send(1'b1); send(1'b0); send(1'b0); end
    chk("loss_pre", 32'(sync), 1);
    send(1'b1);
    chk("loss_drop", 32'(sync), 0);

    // errors spaced by GOOD_RUN good words keep lock
    restart(K_NEG, 3);
    for (int i = 0; i < 6; i++) send(1'b0);
    for (int g = 0; g < 4; g++) begin
      send(1'b1);
      for (int i = 0; i < 4; i++) send(1'b0);
    end
    chk("spaced_hold", 32'(sync), 1);
    for (int i = 0; i < 3; i++) send(1'b1);
    chk("spaced_3err", 32'(sync), 1);
    send(1'b1);
    chk("spaced_4err", 32'(sync), 0);

    // comma at offset 5 plus code_err on the same word counts once
    cycle(10'd0, 1'b1, 1'b0, 1'b1);
    cycle(W0, 1'b1, 1'b0, 1'b0); cycle(W1, 1'b1, 1'b0, 1'b0);
    cycle(W2, 1'b1, 1'b0, 1'b0); cycle(W1, 1'b1, 1'b0, 1'b0);
    cycle(W2, 1'b1, 1'b0, 1'b0); cycle(W1, 1'b1, 1'b0, 1'b0);
    cycle(XW, 1'b1, 1'b0, 1'b0);
    cycle(YW, 1'b1, 1'b1, 1'b0);
    chk("dual_sync", 32'(sync), 1);
    chk("dual_offset", 32'(offset), 3);
    cycle(W2, 1'b1, 1'b1, 1'b0);
    cycle(W1, 1'b1, 1'b1, 1'b0);
    chk("dual_3err", 32'(sync), 1);
    cycle(W2, 1'b1, 1'b1, 1'b0);
    chk("dual_4err", 32'(sync), 0);

    // reset while locked in the middle of a burst, then relock
    cycle(10'd0, 1'b1, 1'b0, 1'b1);
    cycle(W0, 1'b1, 1'b0, 1'b0); cycle(W1, 1'b1, 1'b0, 1'b0);
    cycle(W2, 1'b1, 1'b0, 1'b0); cycle(W1, 1'b1, 1'b0, 1'b0);
    cycle(W2, 1'b1, 1'b0, 1'b0); cycle(W1, 1'b1, 1'b0, 1'b0);
    cycle(W2, 1'b1, 1'b0, 1'b0);
    cycle(W1, 1'b1, 1'b0, 1'b1);
    chk("mrst_sync", 32'(sync), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(data_out), 0);
    cycle(W2, 1'b1, 1'b0, 1'b0); cycle(W1, 1'b1, 1'b0, 1'b0);
    cycle(W2, 1'b1, 1'b0, 1'b0); cycle(W1, 1'b1, 1'b0, 1'b0);
    cycle(W2, 1'b1, 1'b0, 1'b0);
    chk("mrst_no_early", 32'(sync), 0);
    cycle(W1, 1'b1, 1'b0, 1'b0);
    chk("mrst_relock", 32'(sync), 1);

    // randomized stream: comma symbols with slips, gaps, errors, resets
    restart(K_NEG, 0);
    for (int n = 0; n < 4000; n++) begin
      if (bq.size() < 10) begin
        if ($urandom_range(0, 5) == 0) push_bits(10'($urandom), $urandom_range(1, 9));
        ksym = ($urandom_range(0, 1) == 0) ? K_NEG : K_POS;
        push_bits(ksym, 10);
        push_bits(D215, 10);
      end
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 9) < 8);
      e = ($urandom_range(0, 19) == 0);
      if (v) begin
        pop_word(w);
        if ($urandom_range(0, 49) == 0) w = 10'($urandom);
      end else begin
        w = 10'($urandom);
      end
      cycle(w, v, e, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
